// File: rtl/fir_dec_pkg.sv
// Shared defaults and width helpers for the decimating polyphase FIR (fir_dec_poly).
package fir_dec_pkg;

    localparam int WIN_DEF    = 8;
    localparam int COEF_W_DEF = 10;
    localparam int NTAPS_DEF  = 21;
    localparam int DEC_DEF    = 2;
    localparam int WOUT_DEF   = 20;

    // Full-precision sum of NTAPS signed products never overflows at this width.
    function automatic int acc_width(input int win, input int coef_w, input int ntaps);
        return win + coef_w + $clog2(ntaps);
    endfunction

    // A counter for DEC=1 still needs one bit to stay a legal vector.
    function automatic int phase_width(input int dec);
        return (dec > 1) ? $clog2(dec) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_mac.sv
// One transposed-form FIR tap: coefficient register, signed multiplier and MAC register.
module fir_tap_mac
    import fir_dec_pkg::*;
#(
    parameter int WIN     = WIN_DEF,
    parameter int COEF_W  = COEF_W_DEF,
    parameter int ACC_W   = acc_width(WIN_DEF, COEF_W_DEF, NTAPS_DEF),
    parameter int HAS_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              coef_we,
    input  logic [COEF_W-1:0] coef_data,
    input  logic [WIN-1:0]    x,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out
);

    localparam int PRW = WIN + COEF_W;

    logic signed [COEF_W-1:0] coef;
    logic signed [PRW-1:0]    coef_ext;
    logic signed [PRW-1:0]    x_ext;
    logic signed [PRW-1:0]    prod;
    logic        [ACC_W-1:0]  sum;

    // The multiplier reads the pre-edge coefficient, so a write coinciding with a sample
    // only affects the next accepted sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef <= '0;
        end else if (coef_we) begin
            coef <= $signed(coef_data);
        end
    end

    assign coef_ext = PRW'(coef);
    assign x_ext    = PRW'($signed(x));
    assign prod     = coef_ext * x_ext;
    assign sum      = ACC_W'(prod) + acc_in;

    generate
        if (HAS_REG != 0) begin : g_reg
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_out <= '0;
                end else if (clr) begin
                    acc_out <= '0;
                end else if (en) begin
                    acc_out <= sum;
                end
            end
        end else begin : g_comb
            // Tap 0 feeds the output directly, so it carries no state of its own.
            logic unused_ctrl;
            assign unused_ctrl = ^{clr, en};
            assign acc_out     = sum;
        end
    endgenerate

endmodule

// File: rtl/fir_dec_poly.sv
// Transposed-form FIR with decimation by DEC; define FIR_DEC_SAT_EN to saturate Y
// on overflow instead of wrapping to the low WOUT bits.
module fir_dec_poly
    import fir_dec_pkg::*;
#(
    parameter int WIN       = WIN_DEF,
    parameter int COEF_W    = COEF_W_DEF,
    parameter int NTAPS     = NTAPS_DEF,
    parameter int DEC       = DEC_DEF,
    parameter int WOUT      = WOUT_DEF,
    parameter int OUT_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    input  logic [WIN-1:0]           X,
    input  logic                     coef_we,
    input  logic [$clog2(NTAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     out_valid,
    output logic [WOUT-1:0]          Y
);

    localparam int ACC_W = acc_width(WIN, COEF_W, NTAPS);
    localparam int PW    = phase_width(DEC);
    localparam int AW    = $clog2(NTAPS);

    // Handshake: there is no backpressure. A sample is taken on every edge with
    // in_valid=1 (and clr=0); out_valid is a one-cycle pulse the edge after the
    // sample that closes a decimation group, and Y holds until the next pulse.
    logic [ACC_W-1:0]   acc [NTAPS];
    logic [PW-1:0]      phase;
    logic               accept;
    logic               last_phase;
    logic signed [ACC_W-1:0] shifted;
    logic [WOUT-1:0]    y_next;

    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_tap
            logic [ACC_W-1:0] acc_in;
            if (k == NTAPS - 1) begin : g_last
                assign acc_in = '0;
            end else begin : g_mid
                assign acc_in = acc[k+1];
            end

            fir_tap_mac #(
                .WIN     (WIN),
                .COEF_W  (COEF_W),
                .ACC_W   (ACC_W),
                .HAS_REG ((k != 0) ? 1 : 0)
            ) u_tap (
                .clk       (clk),
                .reset     (reset),
                .clr       (clr),
                .en        (in_valid),
                .coef_we   (coef_we && (coef_addr == AW'(k))),
                .coef_data (coef_data),
                .x         (X),
                .acc_in    (acc_in),
                .acc_out   (acc[k])
            );
        end
    endgenerate

    assign accept     = in_valid && !clr;
    assign last_phase = (phase == PW'(DEC - 1));
    assign shifted    = $signed(acc[0]) >>> OUT_SHIFT;

    generate
`ifdef FIR_DEC_SAT_EN
        if (WOUT < ACC_W) begin : g_sat
            localparam logic [WOUT-1:0] MAXV = {1'b0, {(WOUT-1){1'b1}}};
            logic [ACC_W-WOUT:0] hi;
            logic                ovf;
            // In range only when every bit above the output sign bit matches it.
            assign hi     = shifted[ACC_W-1:WOUT-1];
            assign ovf    = !((&hi) || !(|hi));
            assign y_next = ovf ? (shifted[ACC_W-1] ? ~MAXV : MAXV) : shifted[WOUT-1:0];
        end else begin : g_ext
            assign y_next = WOUT'(shifted);
        end
`else
        begin : g_wrap
            assign y_next = WOUT'(shifted);
        end
`endif
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase     <= '0;
            out_valid <= 1'b0;
            Y         <= '0;
        end else begin
            out_valid <= accept && last_phase;
            if (clr) begin
                phase <= '0;
            end else if (in_valid) begin
                phase <= last_phase ? '0 : phase + PW'(1);
            end
            if (accept && last_phase) begin
                Y <= y_next;
            end
        end
    end

endmodule

// File: tb/tb_fir_dec_poly.sv
// Scoreboard bench for fir_dec_poly: DEC=2/WOUT=20 instance (a) and DEC=1/WOUT=16 instance (b).
module tb_fir_dec_poly;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       clr;
    logic       in_valid;
    logic [7:0] X;
    logic       coef_we;
    logic [4:0] coef_addr;
    logic [9:0] coef_data;
    logic       sel;

    logic        a_out_valid, b_out_valid;
    logic [19:0] a_Y;
    logic [15:0] b_Y;

    int checks = 0;
    int errors = 0;
    logic [19:0] exp_a[$];
    logic [15:0] exp_b[$];

    fir_dec_poly #(.WIN(8), .COEF_W(10), .NTAPS(21), .DEC(2), .WOUT(20), .OUT_SHIFT(0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr && !sel),
        .in_valid  (in_valid && !sel),
        .X         (X),
        .coef_we   (coef_we && !sel),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (a_out_valid),
        .Y         (a_Y)
    );

    fir_dec_poly #(.WIN(8), .COEF_W(10), .NTAPS(21), .DEC(1), .WOUT(16), .OUT_SHIFT(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr && sel),
        .in_valid  (in_valid && sel),
        .X         (X),
        .coef_we   (coef_we && sel),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (b_out_valid),
        .Y         (b_Y)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop one expected value per out_valid pulse.
    always @(negedge clk) begin
        if (a_out_valid) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_out: got Y=%0d expected no output", $signed(a_Y));
            end else begin
                check("a_Y", int'($signed(a_Y)), int'($signed(exp_a.pop_front())));
            end
        end
        if (b_out_valid) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_out: got Y=%0d expected no output", $signed(b_Y));
            end else begin
                check("b_Y", int'($signed(b_Y)), int'($signed(exp_b.pop_front())));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            clr      = 1'b0;
            coef_we  = 1'b0;
        end
    endtask

    task automatic send(input int x);
        @(negedge clk);
        in_valid = 1'b1;
        X        = 8'(x);
        clr      = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic send_wr(input int x, input int k, input int d);
        @(negedge clk);
        in_valid  = 1'b1;
        X         = 8'(x);
        clr       = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 5'(k);
        coef_data = 10'(d);
    endtask

    task automatic wr(input int k, input int d);
        @(negedge clk);
        in_valid  = 1'b0;
        clr       = 1'b0;
        coef_we   = 1'b1;
        coef_addr = 5'(k);
        coef_data = 10'(d);
    endtask

    task automatic flush();
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        X        = 8'd99;
        coef_we  = 1'b0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 21; k++) wr(k, k + 1);
        idle(1);
    endtask

    task automatic load_const(input int d);
        for (int k = 0; k < 21; k++) wr(k, d);
        idle(1);
    endtask

    initial begin
        int v;
        int ovf_final;
        reset     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        X         = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        sel       = 1'b0;
        repeat (3) @(negedge clk);
        check("a_Y_reset", int'(a_Y), 0);
        check("a_valid_reset", int'(a_out_valid), 0);
        check("b_Y_reset", int'(b_Y), 0);
        check("b_valid_reset", int'(b_out_valid), 0);
        reset = 1'b1;
        idle(2);

        // Impulse, c[k]=k+1, DEC=2: 2,4,...,20 then 0.
        load_ramp();
        for (int i = 1; i <= 10; i++) exp_a.push_back(20'(2 * i));
        exp_a.push_back(20'd0);
        send(1);
        repeat (21) send(0);
        idle(2);

        // Flush at phase 1; the 3 and the dominated 99 must not appear.
        send(3);
        flush();
        exp_a.push_back(20'd2);
        exp_a.push_back(20'd4);
        send(1); send(0); send(0); send(0);
        idle(2);

        // History 1,0,0,0,1,0 -> c1*1 + c5*1 = 8; then leave dut_a at phase 1.
        exp_a.push_back(20'd8);
        send(1); send(0); send(1);
        idle(3);

        // DC response on dut_b, DEC=1.
        sel = 1'b1;
        load_const(1);
        for (int i = 1; i <= 25; i++) exp_b.push_back(16'(5 * ((i < 21) ? i : 21)));
        repeat (25) send(5);
        idle(2);

        // Same stimulus with gaps 1,0,0,1.
        flush();
        for (int i = 1; i <= 25; i++) exp_b.push_back(16'(5 * ((i < 21) ? i : 21)));
        repeat (25) begin
            send(5);
            idle(2);
        end

        // Coefficient write coinciding with a sample: old c0 for it, new c0=3 after.
        flush();
        exp_b.push_back(16'd5);
        exp_b.push_back(16'd5);
        exp_b.push_back(16'd8);
        send_wr(5, 0, 3);
        send(0);
        send(1);
        idle(2);

        // Overflow: c=511, X=127, WOUT=16.
        load_const(511);
        flush();
        for (int i = 1; i <= 21; i++) begin
            v = i * 64897;
`ifdef FIR_DEC_SAT_EN
            exp_b.push_back(16'h7fff);
`else
            exp_b.push_back(v[15:0]);
`endif
        end
        repeat (21) send(127);
        idle(3);
`ifdef FIR_DEC_SAT_EN
        ovf_final = 32767;
`else
        ovf_final = -13419;
`endif
        check("b_Y_ovf_final", int'($signed(b_Y)), ovf_final);

        // Async reset between edges, then impulse with cleared coefficients.
        sel = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("a_Y_async_reset", int'(a_Y), 0);
        check("a_valid_async_reset", int'(a_out_valid), 0);
        check("b_Y_async_reset", int'(b_Y), 0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        for (int i = 0; i < 11; i++) exp_a.push_back(20'd0);
        send(1);
        repeat (21) send(0);
        idle(3);

        for (int i = 0; i < 100 && (exp_a.size() != 0 || exp_b.size() != 0); i++) @(negedge clk);
        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_dec_poly.md
FIR_DEC_POLY -- requirements
Module: fir_dec_poly

Interface
REQ-001 SHALL have parameter WIN, default 8, meaning signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 10, meaning signed coefficient width.
REQ-003 SHALL have parameter NTAPS, default 21, meaning tap count (2..64).
REQ-004 SHALL have parameter DEC, default 2, meaning decimation factor (1..16).
REQ-005 SHALL have parameter WOUT, default 20, meaning signed output width.
REQ-006 SHALL have parameter OUT_SHIFT, default 0, meaning arithmetic right shift applied before output narrowing.
REQ-007 SHALL have port clk, input, 1, meaning the single clock.
REQ-008 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-009 SHALL have port clr, input, 1, meaning synchronous flush of the datapath.
REQ-010 SHALL have port in_valid, input, 1, meaning sample X is accepted this cycle.
REQ-011 SHALL have port X, input, WIN, meaning signed input sample.
REQ-012 SHALL have port coef_we, input, 1, meaning coefficient write strobe.
REQ-013 SHALL have port coef_addr, input, clog2(NTAPS), meaning tap index k.
REQ-014 SHALL have port coef_data, input, COEF_W, meaning signed coefficient c[k].
REQ-015 SHALL have port out_valid, output, 1, meaning one-cycle pulse marking a decimated output.
REQ-016 SHALL have port Y, output, WOUT, meaning signed filter output.

Function
REQ-017 SHALL implement a transposed-form FIR, y[n] = sum over k=0..NTAPS-1 of c[k]*x[n-k], with x[] indexed by accepted samples only.
REQ-018 SHALL advance the tap pipeline only on cycles with in_valid=1; all MAC registers SHALL hold otherwise.
REQ-019 SHALL keep a phase counter 0..DEC-1 that increments per accepted sample and wraps DEC-1 to 0.
REQ-020 SHALL, on the edge accepting a sample while phase==DEC-1, load Y with y[n] and assert out_valid for exactly the following cycle (latency 1 cycle).
REQ-021 SHALL hold Y between outputs; out_valid SHALL be 0 in all other cycles.
REQ-022 SHALL size the accumulator at ACC_W = WIN+COEF_W+clog2(NTAPS) bits, with no internal overflow.
REQ-023 SHALL form Y from the accumulator arithmetically shifted right by OUT_SHIFT, then narrowed to WOUT bits.
REQ-024 SHALL write coef_data into c[coef_addr] on an edge with coef_we=1, ignoring coef_addr>=NTAPS.
REQ-025 SHALL, when coef_we and in_valid coincide, use the old coefficient for that sample and the new one from the next accepted sample.
REQ-026 SHALL, when clr=1, zero all MAC registers, the phase counter and out_valid; Y and coefficients SHALL hold, and clr SHALL dominate in_valid.
REQ-027 SHALL, with DEC=1, emit an output for every accepted sample.

Reset
REQ-028 SHALL, while reset=0, asynchronously clear all MAC registers, coefficients, phase, Y and out_valid to 0.
REQ-029 SHALL, after reset deasserts mid-stream, restart at phase 0 with an empty history.

Configuration
REQ-030 SHALL, with FIR_DEC_SAT_EN defined, saturate Y to the most positive or most negative WOUT-bit value on overflow.
REQ-031 SHALL, with FIR_DEC_SAT_EN undefined, truncate Y to its low WOUT bits (two's-complement wrap).

Structure
REQ-032 SHALL place the ACC_W computation function, the phase counter width function and the default widths in package fir_dec_pkg.
REQ-033 SHALL instantiate one sub-module, fir_tap_mac (coefficient register, multiplier and MAC register with hold enable), NTAPS times in a generate loop.

Verification
REQ-034 SHALL verify the impulse response: NTAPS=21, DEC=2, c[k]=k+1, input 1 then zeros -> outputs 2,4,...,20, then 0 at the 11th output.
REQ-035 SHALL verify the DC response: all c[k]=1, DEC=1, X=5 held -> Y steps 5,10,...,105, then stays at 105.
REQ-036 SHALL verify gaps: the same stimulus with in_valid toggling 1,0,0,1 -> an identical output sequence, with out_valid pulses only after accepted samples.
REQ-037 SHALL verify overflow: all c[k]=511, X=127, WOUT=16 -> 32767 with FIR_DEC_SAT_EN defined and the wrapped low 16 bits without it.
REQ-038 SHALL verify a mid-stream flush: clr pulsed at phase 1 -> the next out_valid occurs on the DEC-th accepted sample after clr, computed from new samples only.
REQ-039 SHALL verify async reset: reset=0 between clock edges -> Y=0, out_valid=0 and coefficients=0 immediately, with the impulse test then giving all-zero output.
